// File: rtl/present_core_param.sv
// Iterative PRESENT block cipher core, one round per clock, with 80- or 128-bit keys.
// Decryption first expands the key forward to K32, then runs the inverse rounds.
module present_core_param #(
  parameter int KEY_W = 80
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             mode,
  input  logic [63:0]      din,
  input  logic [KEY_W-1:0] key,
  output logic [63:0]      dout,
  output logic             done,
  output logic             busy
);

  generate
    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
      $error("present_core_param: KEY_W must be 80 or 128");
    end
  endgenerate

  // Round-counter injection point and second S-box nibble differ between key sizes.
  localparam int   C_LSB = (KEY_W == 128) ? 62 : 15;
  localparam logic DUAL  = (KEY_W == 128) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, KEXP, ENC, DEC} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hC;
      4'h1: sbox4 = 4'h5;
      4'h2: sbox4 = 4'h6;
      4'h3: sbox4 = 4'hB;
      4'h4: sbox4 = 4'h9;
      4'h5: sbox4 = 4'h0;
      4'h6: sbox4 = 4'hA;
      4'h7: sbox4 = 4'hD;
      4'h8: sbox4 = 4'h3;
      4'h9: sbox4 = 4'hE;
      4'hA: sbox4 = 4'hF;
      4'hB: sbox4 = 4'h8;
      4'hC: sbox4 = 4'h4;
      4'hD: sbox4 = 4'h7;
      4'hE: sbox4 = 4'h1;
      4'hF: sbox4 = 4'h2;
      default: sbox4 = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox4 = 4'h5;
      4'h1: inv_sbox4 = 4'hE;
      4'h2: inv_sbox4 = 4'hF;
      4'h3: inv_sbox4 = 4'h8;
      4'h4: inv_sbox4 = 4'hC;
      4'h5: inv_sbox4 = 4'h1;
      4'h6: inv_sbox4 = 4'h2;
      4'h7: inv_sbox4 = 4'hD;
      4'h8: inv_sbox4 = 4'hB;
      4'h9: inv_sbox4 = 4'h4;
      4'hA: inv_sbox4 = 4'h6;
      4'hB: inv_sbox4 = 4'h3;
      4'hC: inv_sbox4 = 4'h0;
      4'hD: inv_sbox4 = 4'h7;
      4'hE: inv_sbox4 = 4'h9;
      4'hF: inv_sbox4 = 4'hA;
      default: inv_sbox4 = 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] x);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox64(input logic [63:0] x);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] x);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 63; i++) r[i] = x[(16*i) % 63];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox4(r[KEY_W-1 -: 4]);
    r[KEY_W-5 -: 4] = DUAL ? sbox4(r[KEY_W-5 -: 4]) : r[KEY_W-5 -: 4];
    r[C_LSB +: 5]   = r[C_LSB +: 5] ^ c;
    return r;
  endfunction

  // Undoes key_fwd step by step in reverse order.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = k;
    r[C_LSB +: 5]   = r[C_LSB +: 5] ^ c;
    r[KEY_W-1 -: 4] = inv_sbox4(r[KEY_W-1 -: 4]);
    r[KEY_W-5 -: 4] = DUAL ? inv_sbox4(r[KEY_W-5 -: 4]) : r[KEY_W-5 -: 4];
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  state_t           state_q, state_d;
  logic [63:0]      s_q, s_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [4:0]       c_q, c_d;
  logic             mode_q, mode_d;
  logic [63:0]      dout_q, dout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [63:0]      x_s, enc_s, dec_s, round_s, result_s;
  logic [KEY_W-1:0] kf_s, ki_s, knext_s;
  logic             last_s;

  // Round datapath shared by encrypt and decrypt; the latched mode picks the direction.
  always_comb begin
    x_s      = s_q ^ k_q[KEY_W-1 -: 64];
    enc_s    = player(sbox64(x_s));
    dec_s    = inv_sbox64(inv_player(x_s));
    kf_s     = key_fwd(k_q, c_q);
    ki_s     = key_inv(k_q, c_q);
    round_s  = mode_q ? dec_s : enc_s;
    knext_s  = mode_q ? ki_s : kf_s;
    last_s   = mode_q ? (c_q == 5'd1) : (c_q == 5'd31);
    result_s = round_s ^ knext_s[KEY_W-1 -: 64];
  end

  // Next-state logic for the FSM and all registers.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    c_d     = c_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = din;
          k_d     = key;
          c_d     = 5'd1;
          mode_d  = mode;
          state_d = mode ? KEXP : ENC;
        end else begin
          state_d = IDLE;
        end
      end
      KEXP: begin
        k_d = kf_s;
        if (c_q == 5'd31) begin
          c_d     = 5'd31;
          state_d = DEC;
        end else begin
          c_d = c_q + 5'd1;
        end
      end
      ENC, DEC: begin
        s_d = round_s;
        k_d = knext_s;
        if (last_s) begin
          dout_d  = result_s;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          c_d = mode_q ? (c_q - 5'd1) : (c_q + 5'd1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      s_q     <= 64'h0;
      k_q     <= '0;
      c_q     <= 5'd0;
      mode_q  <= 1'b0;
      dout_q  <= 64'h0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
